rename_rat: RTL and testbench

RENAME_RAT -- requirements
Module: rename_rat

---
 rtl/rename_rat.sv | 192 +++++++++++++++++++
 tb/tb_rename_rat.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_rat.sv
// Register rename: speculative/committed RATs plus circular free list; one group of WIDTH slots per cycle.
// Latency 1 (registered outputs held while out_ready low); in_ready drops when the downstream stalls, the free list runs short, or on flush.
module rename_rat #(
   parameter  int WIDTH     = 2,
   parameter  int NUM_AREGS = 32,
   parameter  int NUM_PREGS = 64,
   localparam int PW        = $clog2(NUM_PREGS),
   localparam int AW        = $clog2(NUM_AREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_slot_v,
   input  logic [WIDTH*AW-1:0] in_rs1,
   input  logic [WIDTH*AW-1:0] in_rs2,
   input  logic [WIDTH*AW-1:0] in_rd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_slot_v,
   output logic [WIDTH*PW-1:0] out_ps1,
   output logic [WIDTH*PW-1:0] out_ps2,
   output logic [WIDTH*PW-1:0] out_pd,
   output logic [WIDTH*PW-1:0] out_old_pd,
   input  logic [WIDTH-1:0]    ret_v,
   input  logic [WIDTH*AW-1:0] ret_rd,
   input  logic [WIDTH*PW-1:0] ret_pd,
   input  logic [WIDTH*PW-1:0] ret_old_pd,
   input  logic                flush,
   output logic [PW:0]         free_count
);

   logic [PW-1:0]       spec_rat_q   [NUM_AREGS];
   logic [PW-1:0]       spec_rat_d   [NUM_AREGS];
   logic [PW-1:0]       commit_rat_q [NUM_AREGS];
   logic [PW-1:0]       commit_rat_d [NUM_AREGS];
   logic [PW-1:0]       fl_q         [NUM_PREGS];
   logic [PW-1:0]       fl_d         [NUM_PREGS];
   logic [PW:0]         head_q, head_d, tail_q, tail_d, chead_q, chead_d;
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_slot_v_q, out_slot_v_d;
   logic [WIDTH*PW-1:0] out_ps1_q, out_ps1_d, out_ps2_q, out_ps2_d;
   logic [WIDTH*PW-1:0] out_pd_q, out_pd_d, out_old_pd_q, out_old_pd_d;

   logic [AW-1:0]       rs1_a [WIDTH];
   logic [AW-1:0]       rs2_a [WIDTH];
   logic [AW-1:0]       rd_a  [WIDTH];
   logic [AW-1:0]       ret_rd_a  [WIDTH];
   logic [PW-1:0]       ret_pd_a  [WIDTH];
   logic [PW-1:0]       ret_old_a [WIDTH];
   logic [WIDTH-1:0]    alloc;
   logic [PW-1:0]       ps1_c [WIDTH];
   logic [PW-1:0]       ps2_c [WIDTH];
   logic [PW-1:0]       pd_c  [WIDTH];
   logic [PW-1:0]       old_c [WIDTH];
   logic [PW:0]         n_alloc, n_ret, rd_ptr, wr_ptr, in_flight;
   logic                accept;

   always_comb begin
      for (int j = 0; j < WIDTH; j++) begin
         rs1_a[j]     = in_rs1[j*AW +: AW];
         rs2_a[j]     = in_rs2[j*AW +: AW];
         rd_a[j]      = in_rd[j*AW +: AW];
         ret_rd_a[j]  = ret_rd[j*AW +: AW];
         ret_pd_a[j]  = ret_pd[j*PW +: PW];
         ret_old_a[j] = ret_old_pd[j*PW +: PW];
         alloc[j]     = in_slot_v[j] && (rd_a[j] != '0);
      end
   end

   assign free_count = tail_q - head_q;
   assign in_flight  = head_q - chead_q;
   assign in_ready   = (!out_valid_q || out_ready) && (free_count >= (PW+1)'(WIDTH)) && !flush;
   assign accept     = in_valid && in_ready;

   always_comb begin
      n_alloc = '0;
      rd_ptr  = '0;
      for (int j = 0; j < WIDTH; j++) begin
         ps1_c[j] = spec_rat_q[rs1_a[j]];
         ps2_c[j] = spec_rat_q[rs2_a[j]];
         pd_c[j]  = '0;
         old_c[j] = '0;
         if (alloc[j]) begin
            rd_ptr   = head_q + n_alloc;
            pd_c[j]  = fl_q[rd_ptr[PW-1:0]];
            old_c[j] = spec_rat_q[rd_a[j]];
            n_alloc  = n_alloc + (PW+1)'(1);
         end
         // older in-group writers override the table lookup; the youngest one is visited last
         for (int i = 0; i < j; i++) begin
            if (alloc[i] && rd_a[i] == rs1_a[j]) ps1_c[j] = pd_c[i];
            if (alloc[i] && rd_a[i] == rs2_a[j]) ps2_c[j] = pd_c[i];
            if (alloc[i] && alloc[j] && rd_a[i] == rd_a[j]) old_c[j] = pd_c[i];
         end
      end
   end

   always_comb begin
      spec_rat_d   = spec_rat_q;
      commit_rat_d = commit_rat_q;
      fl_d         = fl_q;
      head_d       = head_q;
      out_valid_d  = out_valid_q;
      out_slot_v_d = out_slot_v_q;
      out_ps1_d    = out_ps1_q;
      out_ps2_d    = out_ps2_q;
      out_pd_d     = out_pd_q;
      out_old_pd_d = out_old_pd_q;
      n_ret        = '0;
      wr_ptr       = '0;

      for (int i = 0; i < WIDTH; i++) begin
         if (ret_v[i] && ret_rd_a[i] != '0) begin
            commit_rat_d[ret_rd_a[i]] = ret_pd_a[i];
            wr_ptr                     = tail_q + n_ret;
            fl_d[wr_ptr[PW-1:0]]       = ret_old_a[i];
            n_ret                      = n_ret + (PW+1)'(1);
         end
      end
      tail_d  = tail_q + n_ret;
      chead_d = chead_q + n_ret;

      if (flush) begin
         out_valid_d = 1'b0;
         head_d      = chead_d;
         spec_rat_d  = commit_rat_d;
      end else if (accept) begin
         head_d       = head_q + n_alloc;
         out_valid_d  = 1'b1;
         out_slot_v_d = in_slot_v;
         for (int j = 0; j < WIDTH; j++) begin
            if (alloc[j]) spec_rat_d[rd_a[j]] = pd_c[j];
            out_ps1_d[j*PW +: PW]    = ps1_c[j];
            out_ps2_d[j*PW +: PW]    = ps2_c[j];
            out_pd_d[j*PW +: PW]     = pd_c[j];
            out_old_pd_d[j*PW +: PW] = old_c[j];
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < NUM_AREGS; a++) begin
            spec_rat_q[a]   <= PW'(a);
            commit_rat_q[a] <= PW'(a);
         end
         for (int p = 0; p < NUM_PREGS; p++) begin
            fl_q[p] <= (p < NUM_PREGS - NUM_AREGS) ? PW'(p + NUM_AREGS) : '0;
         end
         head_q       <= '0;
         chead_q      <= '0;
         tail_q       <= (PW+1)'(NUM_PREGS - NUM_AREGS);
         out_valid_q  <= 1'b0;
         out_slot_v_q <= '0;
         out_ps1_q    <= '0;
         out_ps2_q    <= '0;
         out_pd_q     <= '0;
         out_old_pd_q <= '0;
      end else begin
         spec_rat_q   <= spec_rat_d;
         commit_rat_q <= commit_rat_d;
         fl_q         <= fl_d;
         head_q       <= head_d;
         chead_q      <= chead_d;
         tail_q       <= tail_d;
         out_valid_q  <= out_valid_d;
         out_slot_v_q <= out_slot_v_d;
         out_ps1_q    <= out_ps1_d;
         out_ps2_q    <= out_ps2_d;
         out_pd_q     <= out_pd_d;
         out_old_pd_q <= out_old_pd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (n_ret <= in_flight)
            else $error("rename_rat: retirement exceeds in-flight allocations");
      end
   end

   assign out_valid  = out_valid_q;
   assign out_slot_v = out_slot_v_q;
   assign out_ps1    = out_ps1_q;
   assign out_ps2    = out_ps2_q;
   assign out_pd     = out_pd_q;
   assign out_old_pd = out_old_pd_q;

endmodule

// File: tb/tb_rename_rat.sv
// Bench for rename_rat: directed scenarios plus random traffic against a sequential rename model
// (program-order map table, free-register queue, in-flight list replayed to the free queue on flush).
module tb_rename_rat;
   localparam int W  = 2;
   localparam int AW = 5;
   localparam int PW = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W-1:0]      in_slot_v = '0;
   logic [W*AW-1:0]   in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [W-1:0]      out_slot_v;
   logic [W*PW-1:0]   out_ps1, out_ps2, out_pd, out_old_pd;
   logic [W-1:0]      ret_v = '0;
   logic [W*AW-1:0]   ret_rd = '0;
   logic [W*PW-1:0]   ret_pd = '0, ret_old_pd = '0;
   logic              flush = 1'b0;
   logic [PW:0]       free_count;

   int checks = 0;
   int errors = 0;

   typedef struct {int rd; int pd; int old;} rob_t;
   int   srat [32];
   int   crat [32];
   int   freeq [$];
   rob_t rob [$];
   bit   e_ov;
   int   e_sv;
   int   e_ps1 [W];
   int   e_ps2 [W];
   int   e_pd  [W];
   int   e_old [W];

   rename_rat #(.WIDTH(W), .NUM_AREGS(32), .NUM_PREGS(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_slot_v(in_slot_v),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_slot_v(out_slot_v), .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd),
      .out_old_pd(out_old_pd), .ret_v(ret_v), .ret_rd(ret_rd), .ret_pd(ret_pd),
      .ret_old_pd(ret_old_pd), .flush(flush), .free_count(free_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int fld(input logic [W*PW-1:0] v, input int s);
      return int'(v[s*PW +: PW]);
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 32; a++) begin
         srat[a] = a;
         crat[a] = a;
      end
      freeq.delete();
      for (int p = 32; p < 64; p++) freeq.push_back(p);
      rob.delete();
      e_ov = 1'b0;
      e_sv = 0;
      for (int s = 0; s < W; s++) begin
         e_ps1[s] = 0; e_ps2[s] = 0; e_pd[s] = 0; e_old[s] = 0;
      end
   endtask

   task automatic idle();
      rst = 1'b0; in_valid = 1'b0; in_slot_v = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      ret_v = '0; ret_rd = '0; ret_pd = '0; ret_old_pd = '0; flush = 1'b0; out_ready = 1'b1;
   endtask

   task automatic set_slot(input int s, input int rd, input int r1, input int r2);
      in_slot_v[s]        = 1'b1;
      in_rd[s*AW +: AW]   = AW'(rd);
      in_rs1[s*AW +: AW]  = AW'(r1);
      in_rs2[s*AW +: AW]  = AW'(r2);
   endtask

   task automatic set_ret(input int s, input int k);
      ret_v[s]                = 1'b1;
      ret_rd[s*AW +: AW]      = AW'(rob[k].rd);
      ret_pd[s*PW +: PW]      = PW'(rob[k].pd);
      ret_old_pd[s*PW +: PW]  = PW'(rob[k].old);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   // Check the current outputs against the model, then advance model and DUT by one clock.
   task automatic step();
      bit rdy, acc;
      #1;
      rdy = (!e_ov || out_ready) && (freeq.size() >= W) && !flush;
      chk("in_ready", 32'(in_ready), int'(rdy));
      chk("free_count", 32'(free_count), freeq.size());
      chk("out_valid", 32'(out_valid), int'(e_ov));
      chk("out_slot_v", 32'(out_slot_v), e_sv);
      for (int s = 0; s < W; s++) begin
         chk("out_ps1", 32'(fld(out_ps1, s)), e_ps1[s]);
         chk("out_ps2", 32'(fld(out_ps2, s)), e_ps2[s]);
         chk("out_pd", 32'(fld(out_pd, s)), e_pd[s]);
         chk("out_old_pd", 32'(fld(out_old_pd, s)), e_old[s]);
      end
      acc = in_valid && rdy && !rst;
      if (rst) begin
         model_reset();
      end else begin
         for (int s = 0; s < W; s++) begin
            if (ret_v[s] && ret_rd[s*AW +: AW] != '0) begin
               crat[int'(ret_rd[s*AW +: AW])] = int'(ret_pd[s*PW +: PW]);
               freeq.push_back(int'(ret_old_pd[s*PW +: PW]));
               void'(rob.pop_front());
            end
         end
         if (acc) begin
            for (int s = 0; s < W; s++) begin
               int rd, r1, r2;
               rd = int'(in_rd[s*AW +: AW]);
               r1 = int'(in_rs1[s*AW +: AW]);
               r2 = int'(in_rs2[s*AW +: AW]);
               e_ps1[s] = srat[r1];
               e_ps2[s] = srat[r2];
               e_pd[s]  = 0;
               e_old[s] = 0;
               if (in_slot_v[s] && rd != 0) begin
                  e_old[s] = srat[rd];
                  e_pd[s]  = freeq.pop_front();
                  srat[rd] = e_pd[s];
                  rob.push_back('{rd, e_pd[s], e_old[s]});
               end
            end
            e_sv = int'(in_slot_v);
         end
         if (flush) begin
            for (int k = rob.size() - 1; k >= 0; k--) freeq.push_front(rob[k].pd);
            rob.delete();
            srat = crat;
            e_ov = 1'b0;
         end else if (acc) begin
            e_ov = 1'b1;
         end else if (out_ready) begin
            e_ov = 1'b0;
         end
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_free_count", 32'(free_count), 32);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_pd", 32'(out_pd), 0);

      // two dependent slots
      idle(); in_valid = 1'b1; set_slot(0, 5, 1, 2); set_slot(1, 6, 5, 5); step();
      chk("g_ps1_0", 32'(fld(out_ps1, 0)), 1);
      chk("g_ps2_0", 32'(fld(out_ps2, 0)), 2);
      chk("g_pd_0", 32'(fld(out_pd, 0)), 32);
      chk("g_old_0", 32'(fld(out_old_pd, 0)), 5);
      chk("g_ps1_1", 32'(fld(out_ps1, 1)), 32);
      chk("g_ps2_1", 32'(fld(out_ps2, 1)), 32);
      chk("g_pd_1", 32'(fld(out_pd, 1)), 33);
      chk("g_old_1", 32'(fld(out_old_pd, 1)), 6);
      chk("g_free_count", 32'(free_count), 30);
      idle(); step();

      // same destination in both slots
      do_reset();
      idle(); in_valid = 1'b1; set_slot(0, 7, 0, 0); set_slot(1, 7, 0, 0); step();
      chk("waw_pd_0", 32'(fld(out_pd, 0)), 32);
      chk("waw_pd_1", 32'(fld(out_pd, 1)), 33);
      chk("waw_old_1", 32'(fld(out_old_pd, 1)), 32);
      idle(); in_valid = 1'b1; set_slot(0, 0, 7, 7); step();
      chk("waw_next_ps1", 32'(fld(out_ps1, 0)), 33);
      idle(); step();

      // exhaust the free list, then free two registers
      do_reset();
      for (int g = 0; g < 16; g++) begin
         idle(); in_valid = 1'b1; set_slot(0, 1, 0, 0); set_slot(1, 2, 0, 0); step();
      end
      idle();
      chk("full_free_count", 32'(free_count), 0);
      chk("full_in_ready", 32'(in_ready), 0);
      set_ret(0, 0); step();
      chk("ret1_free_count", 32'(free_count), 1);
      chk("ret1_in_ready", 32'(in_ready), 0);
      idle(); set_ret(0, 0); step();
      chk("ret2_free_count", 32'(free_count), 2);
      chk("ret2_in_ready", 32'(in_ready), 1);
      idle(); in_valid = 1'b1; set_slot(0, 3, 0, 0); step();
      chk("reuse_pd", 32'(fld(out_pd, 0)), 1);
      idle(); step();

      // flush after three unretired groups; offered group must be refused
      do_reset();
      for (int g = 0; g < 3; g++) begin
         idle(); in_valid = 1'b1; set_slot(0, 5, 1, 0); set_slot(1, 6, 5, 0); step();
      end
      idle(); in_valid = 1'b1; set_slot(0, 9, 0, 0); flush = 1'b1; step();
      chk("flush_free_count", 32'(free_count), 32);
      chk("flush_out_valid", 32'(out_valid), 0);
      idle(); in_valid = 1'b1; set_slot(0, 5, 5, 0); step();
      chk("flush_pd", 32'(fld(out_pd, 0)), 32);
      chk("flush_ps1", 32'(fld(out_ps1, 0)), 5);
      idle(); step();

      // x0 destination, then downstream stall
      do_reset();
      idle(); in_valid = 1'b1; set_slot(0, 0, 3, 0); set_slot(1, 9, 0, 0); step();
      chk("x0_pd", 32'(fld(out_pd, 0)), 0);
      chk("x0_old", 32'(fld(out_old_pd, 0)), 0);
      chk("x0_ps1", 32'(fld(out_ps1, 0)), 3);
      chk("x0_pd_1", 32'(fld(out_pd, 1)), 32);
      chk("x0_free_count", 32'(free_count), 31);
      for (int c = 0; c < 5; c++) begin
         idle(); in_valid = 1'b1; set_slot(0, 10, 0, 0); out_ready = 1'b0; step();
         chk("stall_pd_1", 32'(fld(out_pd, 1)), 32);
         chk("stall_in_ready", 32'(in_ready), 0);
         chk("stall_out_valid", 32'(out_valid), 1);
      end
      idle(); in_valid = 1'b1; set_slot(0, 10, 0, 0); step();
      chk("release_pd", 32'(fld(out_pd, 0)), 33);
      idle(); step();

      // random traffic with retire, flush and occasional mid-run reset
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         int nr, lim;
         idle();
         in_valid = ($urandom % 4) != 0;
         for (int s = 0; s < W; s++) begin
            if (($urandom % 4) != 0)
               set_slot(s, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         end
         out_ready = ($urandom % 4) != 0;
         lim = (rob.size() < W) ? rob.size() : W;
         nr = int'($urandom_range(0, lim));
         for (int k = 0; k < nr; k++) set_ret(k, k);
         if (nr < W && ($urandom % 8) == 0) begin
            ret_v[nr] = 1'b1;
            ret_pd[nr*PW +: PW]     = PW'($urandom);
            ret_old_pd[nr*PW +: PW] = PW'($urandom);
         end
         flush = ($urandom % 50) == 0;
         rst   = ($urandom % 300) == 0;
         step();
      end
      idle(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
